// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default register-file widths, link register index and
// register-file FSM state encoding.
package cpu_pkg;

  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned REG_ADDR_W   = 5;
  localparam int unsigned LINK_REG_IDX = 31;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic [0:0] {
    RF_INIT,
    RF_RUN
  } rf_state_e;

endpackage

// File: rtl/regfile_multiport_if.sv
// Decode/writeback side bus of the multi-port register file.
interface regfile_multiport_if
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = REG_ADDR_W,
  parameter int unsigned NUM_RD = 2
);

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     link_en;
  logic [DATA_W-1:0]        link_data;
  logic                     init_done;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, link_en, link_data,
    input  rd_data, init_done
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, link_en, link_data,
    output rd_data, init_done
  );

endinterface

// File: rtl/regfile_multiport_rd_port.sv
// One registered read port with zero-register masking; same-cycle write forwarding
// is compiled in only when REGFILE_BYPASS_EN is defined.
module regfile_rd_port
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned ADDR_W      = REG_ADDR_W,
  parameter int unsigned LINK_REG    = LINK_REG_IDX,
  parameter int unsigned ZERO_REG_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wr_fire,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              link_fire,
  input  logic [DATA_W-1:0] link_data,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [ADDR_W-1:0] LinkAddr = ADDR_W'(LINK_REG);

  logic [DATA_W-1:0] rd_d, rd_q;

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    rd_d = mem_data;
    // Link port wins over the general port, matching the array write priority.
    if (link_fire && (addr == LinkAddr)) begin
      rd_d = link_data;
    end else if (wr_fire && (addr == wr_addr)) begin
      rd_d = wr_data;
    end
    if (!run || ((ZERO_REG_EN != 0) && (addr == '0))) begin
      rd_d = '0;
    end
  end
`else
  logic unused_bypass;
  assign unused_bypass = ^{wr_fire, wr_addr, wr_data, link_fire, link_data, LinkAddr};

  always_comb begin
    rd_d = mem_data;
    if (!run || ((ZERO_REG_EN != 0) && (addr == '0))) begin
      rd_d = '0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign rd_data = rd_q;

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised multi-read register file with link write port and post-reset zeroing sweep.
// Optional same-cycle forwarding: define REGFILE_BYPASS_EN.
module regfile_multiport
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned DEPTH       = 1 << REG_ADDR_W,
  parameter int unsigned NUM_RD      = 2,
  parameter int unsigned LINK_REG    = DEPTH - 1,
  parameter int unsigned ZERO_REG_EN = 1
) (
  input  logic               clk,
  input  logic               rst,
  regfile_multiport_if.slave bus
);

  localparam int unsigned       ADDR_W   = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LinkAddr = ADDR_W'(LINK_REG);

  rf_state_e         state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              init_done_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              run;
  logic              wr_fire;
  logic              link_fire;
  logic [DATA_W-1:0] rd_data_w [NUM_RD];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RF_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        RF_INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastIdx) begin
            state_q     <= RF_RUN;
            init_done_q <= 1'b1;
          end
        end
        RF_RUN: ;
        default: state_q <= RF_INIT;
      endcase
    end
  end

  assign run       = (state_q == RF_RUN);
  assign wr_fire   = run && bus.wr_en && !((ZERO_REG_EN != 0) && (bus.wr_addr == '0));
  assign link_fire = run && bus.link_en && !((ZERO_REG_EN != 0) && (LinkAddr == '0));

  // No reset on the array so it maps to RAM; the sweep and the state gating do the clearing.
  always_ff @(posedge clk) begin
    if (state_q == RF_INIT) begin
      mem_q[cnt_q] <= '0;
    end else begin
      if (wr_fire) begin
        mem_q[bus.wr_addr] <= bus.wr_data;
      end
      if (link_fire) begin
        mem_q[LinkAddr] <= bus.link_data;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr_k;
    assign addr_k = bus.rd_addr[k*ADDR_W +: ADDR_W];

    regfile_rd_port #(
      .DATA_W     (DATA_W),
      .ADDR_W     (ADDR_W),
      .LINK_REG   (LINK_REG),
      .ZERO_REG_EN(ZERO_REG_EN)
    ) u_rd_port (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .addr     (addr_k),
      .mem_data (mem_q[addr_k]),
      .wr_fire  (wr_fire),
      .wr_addr  (bus.wr_addr),
      .wr_data  (bus.wr_data),
      .link_fire(link_fire),
      .link_data(bus.link_data),
      .rd_data  (rd_data_w[k])
    );
  end

  always_comb begin
    bus.rd_data = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      bus.rd_data[k*DATA_W +: DATA_W] = rd_data_w[k];
    end
  end

  assign bus.init_done = init_done_q;

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed self-checking bench for regfile_multiport (default 32x32, two read ports).
module tb_regfile_multiport;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  regfile_multiport_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus_if ();

  regfile_multiport #(
    .DATA_W     (DW),
    .DEPTH      (32),
    .NUM_RD     (NR),
    .LINK_REG   (31),
    .ZERO_REG_EN(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [DW-1:0] rd0 = bus_if.rd_data[DW-1:0];
  wire [DW-1:0] rd1 = bus_if.rd_data[2*DW-1:DW];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    bus_if.rd_addr = {a1, a0};
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus_if.wr_en   = 1'b1;
    bus_if.wr_addr = a;
    bus_if.wr_data = d;
    tick();
    bus_if.wr_en = 1'b0;
  endtask

  task automatic test_reset();
    int cycles;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (bus_if.init_done !== 1'b0) $display("FAIL reset_init_done got %b want 0", bus_if.init_done);
    else n_pass++;
    n_checks++;
    if (bus_if.rd_data !== '0) $display("FAIL reset_rd_data got %h want 0", bus_if.rd_data);
    else n_pass++;
    tick();
    tick();
    rst = 1'b1;
    // Writes attempted during the sweep must be ignored.
    bus_if.wr_en     = 1'b1;
    bus_if.wr_addr   = 5'd4;
    bus_if.wr_data   = 32'hCAFE_F00D;
    bus_if.link_en   = 1'b1;
    bus_if.link_data = 32'h1234_0000;
    set_rd(5'd4, 5'd31);
    cycles = 0;
    while (!bus_if.init_done && cycles < 100) begin
      tick();
      cycles++;
      if (cycles == 10) begin
        n_checks++;
        if (bus_if.rd_data !== '0) $display("FAIL init_rd_held got %h want 0", bus_if.rd_data);
        else n_pass++;
      end
    end
    bus_if.wr_en   = 1'b0;
    bus_if.link_en = 1'b0;
    n_checks++;
    if (cycles != 32) $display("FAIL init_sweep_cycles got %0d want 32", cycles);
    else n_pass++;
  endtask

  task automatic test_init_zero();
    int bad;
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      set_rd(AW'(i), AW'(31 - i));
      tick();
      if (rd0 !== 32'h0 || rd1 !== 32'h0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL init_all_zero got %0d nonzero reads want 0", bad);
    else n_pass++;
  endtask

  task automatic test_basic();
    write(5'd5, 32'hDEAD_BEEF);
    set_rd(5'd5, 5'd5);
    tick();
    n_checks++;
    if (rd0 !== 32'hDEAD_BEEF) $display("FAIL basic_port0 got %h want deadbeef", rd0);
    else n_pass++;
    n_checks++;
    if (rd1 !== 32'hDEAD_BEEF) $display("FAIL basic_port1 got %h want deadbeef", rd1);
    else n_pass++;
  endtask

  task automatic test_zero_reg();
    write(5'd0, 32'h1234_5678);
    set_rd(5'd0, 5'd5);
    tick();
    n_checks++;
    if (rd0 !== 32'h0) $display("FAIL zero_reg got %h want 0", rd0);
    else n_pass++;
    n_checks++;
    if (rd1 !== 32'hDEAD_BEEF) $display("FAIL zero_reg_other got %h want deadbeef", rd1);
    else n_pass++;
    // Same-cycle write/read of register 0 must read 0 in either build.
    bus_if.wr_en   = 1'b1;
    bus_if.wr_addr = 5'd0;
    bus_if.wr_data = 32'hFFFF_FFFF;
    set_rd(5'd0, 5'd0);
    tick();
    bus_if.wr_en = 1'b0;
    n_checks++;
    if (rd0 !== 32'h0) $display("FAIL zero_reg_collide got %h want 0", rd0);
    else n_pass++;
  endtask

  task automatic test_link_priority();
    bus_if.wr_en     = 1'b1;
    bus_if.wr_addr   = 5'd31;
    bus_if.wr_data   = 32'h0000_1111;
    bus_if.link_en   = 1'b1;
    bus_if.link_data = 32'h0040_0008;
    tick();
    bus_if.wr_en   = 1'b0;
    bus_if.link_en = 1'b0;
    set_rd(5'd31, 5'd31);
    tick();
    n_checks++;
    if (rd0 !== 32'h0040_0008) $display("FAIL link_priority got %h want 00400008", rd0);
    else n_pass++;
    // Both ports landing in different registers in one cycle.
    bus_if.wr_en     = 1'b1;
    bus_if.wr_addr   = 5'd9;
    bus_if.wr_data   = 32'h0000_0099;
    bus_if.link_en   = 1'b1;
    bus_if.link_data = 32'h0040_0010;
    tick();
    bus_if.wr_en   = 1'b0;
    bus_if.link_en = 1'b0;
    set_rd(5'd9, 5'd31);
    tick();
    n_checks++;
    if (rd0 !== 32'h0000_0099) $display("FAIL dual_write_wr got %h want 00000099", rd0);
    else n_pass++;
    n_checks++;
    if (rd1 !== 32'h0040_0010) $display("FAIL dual_write_link got %h want 00400010", rd1);
    else n_pass++;
  endtask

  task automatic test_collision();
    logic [DW-1:0] exp_first;
    logic [DW-1:0] exp_link;
    write(5'd7, 32'hA);
    bus_if.wr_en   = 1'b1;
    bus_if.wr_addr = 5'd7;
    bus_if.wr_data = 32'hB;
    set_rd(5'd7, 5'd7);
    tick();
    bus_if.wr_en = 1'b0;
`ifdef REGFILE_BYPASS_EN
    exp_first = 32'hB;
`else
    exp_first = 32'hA;
`endif
    n_checks++;
    if (rd0 !== exp_first) $display("FAIL collide_first got %h want %h", rd0, exp_first);
    else n_pass++;
    tick();
    n_checks++;
    if (rd0 !== 32'hB) $display("FAIL collide_second got %h want 0000000b", rd0);
    else n_pass++;
    // Both write ports hitting the register being read.
    bus_if.wr_en     = 1'b1;
    bus_if.wr_addr   = 5'd31;
    bus_if.wr_data   = 32'h2222;
    bus_if.link_en   = 1'b1;
    bus_if.link_data = 32'h3333;
    set_rd(5'd7, 5'd31);
    tick();
    bus_if.wr_en   = 1'b0;
    bus_if.link_en = 1'b0;
`ifdef REGFILE_BYPASS_EN
    exp_link = 32'h3333;
`else
    exp_link = 32'h0040_0010;
`endif
    n_checks++;
    if (rd1 !== exp_link) $display("FAIL collide_link got %h want %h", rd1, exp_link);
    else n_pass++;
    tick();
    n_checks++;
    if (rd1 !== 32'h3333) $display("FAIL collide_link_after got %h want 00003333", rd1);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      bus_if.wr_en   = 1'b1;
      bus_if.wr_addr = AW'(10 + i);
      bus_if.wr_data = 32'h100 + 32'(i);
      tick();
    end
    bus_if.wr_en = 1'b0;
    set_rd(5'd10, 5'd13);
    tick();
    n_checks++;
    if (rd0 !== 32'h100 || rd1 !== 32'h103)
      $display("FAIL b2b_10_13 got %h/%h want 00000100/00000103", rd0, rd1);
    else n_pass++;
    set_rd(5'd12, 5'd11);
    tick();
    n_checks++;
    if (rd0 !== 32'h102 || rd1 !== 32'h101)
      $display("FAIL b2b_12_11 got %h/%h want 00000102/00000101", rd0, rd1);
    else n_pass++;
  endtask

  task automatic test_reset_midrun();
    int cycles;
    write(5'd3, 32'h55);
    set_rd(5'd3, 5'd3);
    tick();
    n_checks++;
    if (rd0 !== 32'h55) $display("FAIL midrun_setup got %h want 00000055", rd0);
    else n_pass++;
    rst = 1'b0;
    bus_if.wr_en   = 1'b1;
    bus_if.wr_addr = 5'd3;
    bus_if.wr_data = 32'h77;
    #1;
    n_checks++;
    if (bus_if.rd_data !== '0 || bus_if.init_done !== 1'b0)
      $display("FAIL midrun_async got %h/%b want 0/0", bus_if.rd_data, bus_if.init_done);
    else n_pass++;
    tick();
    rst = 1'b1;
    bus_if.wr_en = 1'b0;
    cycles = 0;
    while (!bus_if.init_done && cycles < 100) begin
      tick();
      cycles++;
    end
    n_checks++;
    if (cycles != 32) $display("FAIL midrun_sweep_cycles got %0d want 32", cycles);
    else n_pass++;
    set_rd(5'd3, 5'd5);
    tick();
    n_checks++;
    if (rd0 !== 32'h0 || rd1 !== 32'h0)
      $display("FAIL midrun_cleared got %h/%h want 0/0", rd0, rd1);
    else n_pass++;
  endtask

  initial begin
    rst              = 1'b1;
    bus_if.rd_addr   = '0;
    bus_if.wr_en     = 1'b0;
    bus_if.wr_addr   = '0;
    bus_if.wr_data   = '0;
    bus_if.link_en   = 1'b0;
    bus_if.link_data = '0;
    test_reset();
    test_init_zero();
    test_basic();
    test_zero_reg();
    test_link_priority();
    test_collision();
    test_back_to_back();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
